display_7seg_mux: RTL and testbench
===================================

# display_7seg_mux

Multiplexed 8-digit seven-segment driver for the microwave front panel. Sits directly downstream of the countdown timer: consumes its remaining minutes/seconds and its run/pause status and drives the board's anode and cathode lines. Shows time as `MM.SS` on the four rightmost digits, with blanking and pause blinking. Frame-synchronous input capture prevents torn values mid-scan.

## Interface
- `REFRESH_COUNT`, 100_000: clock cycles each digit stays lit (1 kHz per digit at 100 MHz).
- `BLINK_COUNT`, 25_000_000: clock cycles per blink half-period (2 Hz toggle at 100 MHz).
- `clock`  in  1: single system clock; all state on its rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `min`  in  7: minutes from the timer, valid range 0..99.
- `sec`  in  7: seconds from the timer, valid range 0..59.
- `blank`  in  1: 1 forces every digit off.
- `blink`  in  1: 1 blinks the time digits; used while the timer is paused.
- `an`  out  8: digit anodes, active-low, one-hot-low while a digit is lit.
- `dec_cat`  out  8: cathodes, active-low, `{dp,g,f,e,d,c,b,a}`.

## Operation
- Refresh counter `rcnt` counts 0..REFRESH_COUNT-1. On the wrap it issues `tick`, and digit index `idx` (3 bits) increments modulo 8.
- Frame latch: on the `tick` that takes `idx` 7→0, capture `min`, `sec`, `blank` and `blink` into shadow registers. Only the shadow values drive the display.
- Digit map:
  - idx0 = seconds ones, idx1 = seconds tens, idx2 = minutes ones with dp lit, idx3 = minutes tens.
  - idx4..7 are always dark (`an` all 1, `dec_cat` = 8'hFF).
  - Leading zeros are shown, so 0 min 5 s displays `00.05`.
- Binary to BCD is combinational on the shadow values: tens = v/10, ones = v%10, valid for v ≤ 99.
- Out-of-range input (shadow min > 99 or sec > 59): digits 0..3 all show `-` (`dec_cat[6:0]` = 7'b0111111). idx2 keeps its dp.
- Segment codes for `{g..a}`, active-low:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
- Blink phase register `vis`:
  - Counter `bcnt` runs 0..BLINK_COUNT-1 while shadow `blink` = 1; `vis` toggles on each wrap.
  - While shadow `blink` = 0: `bcnt` is held at 0 and `vis` = 1.
  - Entering blink therefore always starts in the visible phase.
- Output decision, priority order: shadow `blank` = 1, or `vis` = 0 → `an` = 8'hFF, `dec_cat` = 8'hFF. Otherwise `an` = ~(1<<idx) for idx 0..3, else 8'hFF.

## Timing
- Reset values: `an` = 8'hFF, `dec_cat` = 8'hFF, `rcnt` = 0, `idx` = 0, `bcnt` = 0, `vis` = 1, all shadows 0.
- `an`/`dec_cat` are registered and change 1 cycle after the `tick` that updates `idx`.
- `an` and `dec_cat` update on the same edge; there is never a cycle where a new anode is paired with old cathodes.
- Input-to-display latency: a change on `min`/`sec` appears at the next frame latch. Worst case is 8·REFRESH_COUNT + 1 cycles.
- Inputs are sampled only at the frame latch; changes inside a frame are ignored until the next one.
- Reset asserted mid-scan: outputs go dark immediately (asynchronous). After deassertion the scan restarts at idx0 with shadow value 0 until the first frame latch.
- `blank` and `blink` both 1: `blank` wins, outputs are dark, and the blink counter keeps running.

## Structure
- Shared package `display_pkg`:
  - segment constants `SEG_0..SEG_9`, `SEG_DASH`, `SEG_OFF`;
  - digit-position constants;
  - default counts `REFRESH_COUNT` and `BLINK_COUNT`.
- One sub-module, `bin2bcd_2d`: 7-bit binary → two 4-bit BCD digits, purely combinational, instantiated once for `min` and once for `sec`.

## Test plan
Bench uses REFRESH_COUNT=4, BLINK_COUNT=64.
- **Reset:** hold `reset`=0 for 3 cycles → `an`=8'hFF, `dec_cat`=8'hFF. After release, first frame shows `00.00`.
- **Normal display:** min=12, sec=34 → over one frame `an` cycles FE,FD,FB,F7. `dec_cat` = 8'b10011001, 8'b10110000, 8'b00100100 (dp on), 8'b11111001. idx4..7 dark.
- **Out of range:** sec=75, min=3 → digits 0..3 show 8'hBF, 8'hBF, 8'h3F, 8'hBF.
- **Mid-frame change:** change `min` 5→6 while idx=1 → digit2 keeps showing 5 until the next idx7→0 latch, then shows 6.
- **Blink:** blink=1 → first 64 cycles after the latch lit, next 64 cycles `an`=8'hFF, and so on. Dropping blink=0 → lit from the next frame.
- **Blank priority and async reset:** blank=1 with blink=1 → dark throughout. Pulling `reset` low mid-frame at idx2 → `an`=8'hFF within the same cycle, with no clock edge needed.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants for the seven-segment display driver.
// Segment codes are active-low {g,f,e,d,c,b,a}; the dp cathode is added
// separately by the driver. Digit positions name the four lit scan slots.
package display_pkg;

    // Default timing at 100 MHz: 1 kHz per digit, 2 Hz blink toggle.
    localparam int unsigned REFRESH_COUNT = 100_000;
    localparam int unsigned BLINK_COUNT   = 25_000_000;

    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [7:0] AN_OFF  = 8'hFF;
    localparam logic [7:0] CAT_OFF = 8'hFF;

    localparam logic [2:0] DIG_SEC_ONES = 3'd0;
    localparam logic [2:0] DIG_SEC_TENS = 3'd1;
    localparam logic [2:0] DIG_MIN_ONES = 3'd2;
    localparam logic [2:0] DIG_MIN_TENS = 3'd3;

    // BCD digit to active-low segment pattern; non-decimal codes stay dark.
    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_OFF;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/display_7seg_mux_bin2bcd.sv
// Two-digit binary to BCD converter, purely combinational.
//   bin_i  : 7-bit binary value, meaningful for 0..99
//   tens_o : bin_i / 10 (low 4 bits)
//   ones_o : bin_i % 10
module bin2bcd_2d (
    input  logic [6:0] bin_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o
);

    always_comb begin
        tens_o = 4'(bin_i / 7'd10);
        ones_o = 4'(bin_i % 7'd10);
    end

endmodule

// File: rtl/display_7seg_mux.sv
// Multiplexed 8-digit seven-segment driver showing MM.SS on digits 0..3.
//   clock   : system clock, all state on the rising edge
//   reset   : asynchronous, active-low
//   min     : minutes 0..99      sec  : seconds 0..59
//   blank   : 1 forces all digits off
//   blink   : 1 blinks the time digits (paused timer)
//   an      : active-low anodes, one-hot-low while a digit is lit
//   dec_cat : active-low cathodes {dp,g,f,e,d,c,b,a}
// Inputs are captured once per scan frame so a digit sweep never mixes
// values from two different timer readings.
module display_7seg_mux #(
    parameter int unsigned REFRESH_COUNT = display_pkg::REFRESH_COUNT,
    parameter int unsigned BLINK_COUNT   = display_pkg::BLINK_COUNT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] min,
    input  logic [6:0] sec,
    input  logic       blank,
    input  logic       blink,
    output logic [7:0] an,
    output logic [7:0] dec_cat
);

    import display_pkg::*;

    localparam int unsigned RW = (REFRESH_COUNT > 1) ? $clog2(REFRESH_COUNT) : 1;
    localparam int unsigned BW = (BLINK_COUNT > 1) ? $clog2(BLINK_COUNT) : 1;

    logic [RW-1:0] rcnt_q, rcnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [6:0]    min_sh_q, min_sh_d;
    logic [6:0]    sec_sh_q, sec_sh_d;
    logic          blank_sh_q, blank_sh_d;
    logic          blink_sh_q, blink_sh_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          vis_q, vis_d;
    logic [7:0]    an_q, an_d;
    logic [7:0]    cat_q, cat_d;

    logic          tick;
    logic          frame_latch;
    logic [3:0]    min_tens, min_ones, sec_tens, sec_ones;
    logic [3:0]    digit;
    logic          out_of_range;
    logic          shown;
    logic [6:0]    seg;
    logic          dp_n;

    bin2bcd_2d u_min_bcd (
        .bin_i  (min_sh_q),
        .tens_o (min_tens),
        .ones_o (min_ones)
    );

    bin2bcd_2d u_sec_bcd (
        .bin_i  (sec_sh_q),
        .tens_o (sec_tens),
        .ones_o (sec_ones)
    );

    // Scan timing and frame capture
    always_comb begin
        tick        = (rcnt_q == RW'(REFRESH_COUNT - 1));
        frame_latch = tick && (idx_q == 3'd7);
        rcnt_d      = tick ? '0 : rcnt_q + RW'(1);
        idx_d       = tick ? idx_q + 3'd1 : idx_q;

        min_sh_d   = min_sh_q;
        sec_sh_d   = sec_sh_q;
        blank_sh_d = blank_sh_q;
        blink_sh_d = blink_sh_q;
        if (frame_latch) begin
            min_sh_d   = min;
            sec_sh_d   = sec;
            blank_sh_d = blank;
            blink_sh_d = blink;
        end
    end

    // Blink phase: held visible while not blinking so each blink episode
    // starts with a full lit half-period.
    always_comb begin
        bcnt_d = '0;
        vis_d  = 1'b1;
        if (blink_sh_q) begin
            if (bcnt_q == BW'(BLINK_COUNT - 1)) begin
                bcnt_d = '0;
                vis_d  = ~vis_q;
            end else begin
                bcnt_d = bcnt_q + BW'(1);
                vis_d  = vis_q;
            end
        end
    end

    // Digit select and output decision for the current scan slot
    always_comb begin
        case (idx_q)
            DIG_SEC_ONES: digit = sec_ones;
            DIG_SEC_TENS: digit = sec_tens;
            DIG_MIN_ONES: digit = min_ones;
            DIG_MIN_TENS: digit = min_tens;
            default:      digit = '0;
        endcase

        out_of_range = (min_sh_q > 7'd99) || (sec_sh_q > 7'd59);
        seg          = out_of_range ? SEG_DASH : seg_encode(digit);
        dp_n         = (idx_q == DIG_MIN_ONES) ? 1'b0 : 1'b1;

        // vis_q only matters while blinking; it can lag one cycle after a
        // blink exit, so gate it with the shadow blink flag.
        shown = !blank_sh_q && (vis_q || !blink_sh_q) && !idx_q[2];

        an_d  = AN_OFF;
        cat_d = CAT_OFF;
        if (shown) begin
            an_d  = ~(8'b1 << idx_q);
            cat_d = {dp_n, seg};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rcnt_q     <= '0;
            idx_q      <= '0;
            min_sh_q   <= '0;
            sec_sh_q   <= '0;
            blank_sh_q <= 1'b0;
            blink_sh_q <= 1'b0;
            bcnt_q     <= '0;
            vis_q      <= 1'b1;
            an_q       <= AN_OFF;
            cat_q      <= CAT_OFF;
        end else begin
            rcnt_q     <= rcnt_d;
            idx_q      <= idx_d;
            min_sh_q   <= min_sh_d;
            sec_sh_q   <= sec_sh_d;
            blank_sh_q <= blank_sh_d;
            blink_sh_q <= blink_sh_d;
            bcnt_q     <= bcnt_d;
            vis_q      <= vis_d;
            an_q       <= an_d;
            cat_q      <= cat_d;
        end
    end

    assign an      = an_q;
    assign dec_cat = cat_q;

endmodule

// File: tb/tb_display_7seg_mux.sv
// Bench for display_7seg_mux with short refresh/blink counts.
module tb_display_7seg_mux;

    localparam int unsigned R     = 4;
    localparam int unsigned B     = 64;
    localparam int unsigned FRAME = 8 * R;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] min   = '0;
    logic [6:0] sec   = '0;
    logic       blank = 1'b0;
    logic       blink = 1'b0;
    logic [7:0] an;
    logic [7:0] dec_cat;

    int errors = 0;
    int checks = 0;

    display_7seg_mux #(
        .REFRESH_COUNT(R),
        .BLINK_COUNT  (B)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .min     (min),
        .sec     (sec),
        .blank   (blank),
        .blink   (blink),
        .an      (an),
        .dec_cat (dec_cat)
    );

    always #5 clock = ~clock;

    // Reference model: position in the scan is derived from the number of
    // clock edges since reset; blink phase from edges spent blinking.
    logic [6:0]  segs [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};
    int unsigned cyc     = 0;
    int unsigned bedges  = 0;
    int          sh_min  = 0;
    int          sh_sec  = 0;
    bit          sh_blank = 1'b0;
    bit          sh_blink = 1'b0;
    logic [7:0]  exp_an  = 8'hFF;
    logic [7:0]  exp_cat = 8'hFF;

    function automatic void model_out(input int unsigned cc,
                                      output logic [7:0] a, output logic [7:0] k);
        int unsigned idx;
        int          v;
        bit          vis;
        logic [6:0]  s;
        idx = (cc / R) % 8;
        vis = ((bedges / B) % 2) == 0;
        a = 8'hFF;
        k = 8'hFF;
        if (!sh_blank && !(sh_blink && !vis) && idx < 4) begin
            case (idx)
                0:       v = sh_sec % 10;
                1:       v = sh_sec / 10;
                2:       v = sh_min % 10;
                default: v = sh_min / 10;
            endcase
            if (sh_min > 99 || sh_sec > 59) s = 7'b0111111;
            else                            s = segs[v];
            a = ~(8'h01 << idx);
            k = {(idx == 2) ? 1'b0 : 1'b1, s};
        end
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            cyc      = 0;
            bedges   = 0;
            sh_min   = 0;
            sh_sec   = 0;
            sh_blank = 1'b0;
            sh_blink = 1'b0;
            exp_an   = 8'hFF;
            exp_cat  = 8'hFF;
        end else begin
            model_out(cyc, exp_an, exp_cat);
            bedges = sh_blink ? bedges + 1 : 0;
            if (cyc % FRAME == FRAME - 1) begin
                sh_min   = int'(min);
                sh_sec   = int'(sec);
                sh_blank = blank;
                sh_blink = blink;
            end
            cyc = cyc + 1;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clock) begin
        checks++;
        if (an !== exp_an) begin
            errors++;
            $display("FAIL model_an t=%0t: got %h expected %h", $time, an, exp_an);
        end
        checks++;
        if (dec_cat !== exp_cat) begin
            errors++;
            $display("FAIL model_cat t=%0t: got %h expected %h", $time, dec_cat, exp_cat);
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s t=%0t: got %h expected %h", name, $time, act, expv);
        end
    endtask

    // Advance to the negedge where digit 0 of a fresh frame is on the outputs.
    task automatic wait_frame_start();
        int n = 0;
        do begin
            @(negedge clock);
            n++;
        end while ((cyc % FRAME) != 1 && n < 200);
        if ((cyc % FRAME) != 1) begin
            checks++;
            errors++;
            $display("FAIL frame_sync: got cyc %0d expected frame start", cyc);
        end
    endtask

    task automatic check_frame(input string name, input bit lit,
                               input logic [7:0] d0, input logic [7:0] d1,
                               input logic [7:0] d2, input logic [7:0] d3);
        logic [7:0] ea [8];
        logic [7:0] ed [8];
        ea = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        ed = '{d0, d1, d2, d3, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        if (!lit) begin
            for (int i = 0; i < 8; i++) begin
                ea[i] = 8'hFF;
                ed[i] = 8'hFF;
            end
        end
        wait_frame_start();
        for (int i = 0; i < 8; i++) begin
            chk({name, "_an"}, an, ea[i]);
            chk({name, "_cat"}, dec_cat, ed[i]);
            repeat (R) @(negedge clock);
        end
    endtask

    initial begin
        // Reset
        repeat (3) @(negedge clock);
        chk("reset_an", an, 8'hFF);
        chk("reset_cat", dec_cat, 8'hFF);
        reset = 1'b1;
        check_frame("zero", 1'b1, 8'hC0, 8'hC0, 8'h40, 8'hC0);

        // Normal display 12.34
        min = 7'd12;
        sec = 7'd34;
        check_frame("norm", 1'b1, 8'h99, 8'hB0, 8'h24, 8'hF9);

        // Out of range seconds
        min = 7'd3;
        sec = 7'd75;
        check_frame("oor", 1'b1, 8'hBF, 8'hBF, 8'h3F, 8'hBF);

        // Mid-frame change is held off until the next latch
        min = 7'd5;
        sec = 7'd0;
        check_frame("five", 1'b1, 8'hC0, 8'hC0, 8'h12, 8'hC0);
        repeat (5) @(negedge clock);
        min = 7'd6;
        repeat (4) @(negedge clock);
        chk("midframe_an", an, 8'hFB);
        chk("midframe_cat", dec_cat, 8'h12);
        check_frame("six", 1'b1, 8'hC0, 8'hC0, 8'h02, 8'hC0);

        // Blink: 64 cycles lit, 64 dark after the latch
        blink = 1'b1;
        min   = 7'd1;
        sec   = 7'd2;
        wait_frame_start();
        chk("blink_0", an, 8'hFE);
        repeat (32) @(negedge clock);
        chk("blink_32", an, 8'hFE);
        repeat (32) @(negedge clock);
        chk("blink_64", an, 8'hFF);
        repeat (32) @(negedge clock);
        chk("blink_96", an, 8'hFF);
        repeat (32) @(negedge clock);
        chk("blink_128", an, 8'hFE);
        blink = 1'b0;
        check_frame("unblink", 1'b1, 8'hA4, 8'hC0, 8'h79, 8'hC0);

        // Blank wins over blink
        blank = 1'b1;
        blink = 1'b1;
        check_frame("blank_a", 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        check_frame("blank_b", 1'b0, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        blank = 1'b0;
        blink = 1'b0;
        min   = 7'd12;
        sec   = 7'd34;
        check_frame("restore", 1'b1, 8'h99, 8'hB0, 8'h24, 8'hF9);

        // Asynchronous reset while digit 2 is lit
        repeat (9) @(negedge clock);
        chk("pre_rst_an", an, 8'hFB);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_an", an, 8'hFF);
        chk("async_rst_cat", dec_cat, 8'hFF);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        check_frame("after_rst", 1'b1, 8'hC0, 8'hC0, 8'h40, 8'hC0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
